// File: rtl/vx_tcu_csr_regs.sv
// Tensor configuration/status register bank shared by the tensor core (write + paired read)
// and the core CSR port. Reads are registered with write-first forwarding.
module vx_tcu_csr_regs #(
  parameter int unsigned          NUM_REGS  = 8,
  parameter int unsigned          ADDR_BITS = 12,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR = ADDR_BITS'(12'hCC0)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tcu_write_enable,
  input  logic [ADDR_BITS-1:0] tcu_write_addr,
  input  logic [31:0]          tcu_write_data,
  input  logic                 tcu_read_enable,
  input  logic [ADDR_BITS-1:0] tcu_read_addr,
  output logic [31:0]          tcu_read_data_a,
  output logic [31:0]          tcu_read_data_b,
  input  logic                 core_write_enable,
  input  logic [ADDR_BITS-1:0] core_write_addr,
  input  logic [31:0]          core_write_data,
  input  logic                 core_read_enable,
  input  logic [ADDR_BITS-1:0] core_read_addr,
  output logic [31:0]          core_read_data,
  output logic                 oob_error
);

  localparam int unsigned          IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_BITS-1:0] NUM_REGS_A = ADDR_BITS'(NUM_REGS);
  localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_REGS - 1);

  function automatic logic [ADDR_BITS-1:0] offset(input logic [ADDR_BITS-1:0] addr);
    return addr - BASE_ADDR;
  endfunction

  function automatic logic hit(input logic [ADDR_BITS-1:0] addr);
    return (addr >= BASE_ADDR) && (offset(addr) < NUM_REGS_A);
  endfunction

  logic [31:0] regs     [NUM_REGS];
  logic [31:0] regs_nxt [NUM_REGS];

  logic             tw_hit, cw_hit, tr_hit, cr_hit;
  logic [IDX_W-1:0] tw_idx, cw_idx, tr_idx, cr_idx;
  logic [31:0]      rd_a, rd_b, rd_core;
  logic             oob_now;

  assign tw_hit = hit(tcu_write_addr);
  assign cw_hit = hit(core_write_addr);
  assign tr_hit = hit(tcu_read_addr);
  assign cr_hit = hit(core_read_addr);

  assign tw_idx = IDX_W'(offset(tcu_write_addr));
  assign cw_idx = IDX_W'(offset(core_write_addr));
  assign tr_idx = IDX_W'(offset(tcu_read_addr));
  assign cr_idx = IDX_W'(offset(core_read_addr));

  assign oob_now = (tcu_write_enable && !tw_hit) || (tcu_read_enable && !tr_hit);

  // Reads sample the post-write image, so same-cycle writes are forwarded;
  // the tcu write is applied last so it wins an address collision.
  always_comb begin
    regs_nxt = regs;
    if (core_write_enable && cw_hit) regs_nxt[cw_idx] = core_write_data;
    if (tcu_write_enable && tw_hit)  regs_nxt[tw_idx] = tcu_write_data;

    rd_a    = '0;
    rd_b    = '0;
    rd_core = '0;
    if (tr_hit) begin
      rd_a = regs_nxt[tr_idx];
      if (tr_idx != LAST_IDX) rd_b = regs_nxt[tr_idx + 1'b1];
    end
    if (cr_hit) rd_core = regs_nxt[cr_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      tcu_read_data_a <= '0;
      tcu_read_data_b <= '0;
      core_read_data  <= '0;
      oob_error       <= 1'b0;
    end else begin
      regs <= regs_nxt;
      if (tcu_read_enable) begin
        tcu_read_data_a <= rd_a;
        tcu_read_data_b <= rd_b;
      end
      if (core_read_enable) core_read_data <= rd_core;
      if (oob_now) oob_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vx_tcu_csr_regs.sv
// Self-checking bench for vx_tcu_csr_regs: a register-bank model feeds a scoreboard of
// expected read results that each test pops and compares after the read's latency.
module tb_vx_tcu_csr_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        tcu_write_enable;
  logic [11:0] tcu_write_addr;
  logic [31:0] tcu_write_data;
  logic        tcu_read_enable;
  logic [11:0] tcu_read_addr;
  logic [31:0] tcu_read_data_a;
  logic [31:0] tcu_read_data_b;
  logic        core_write_enable;
  logic [11:0] core_write_addr;
  logic [31:0] core_write_data;
  logic        core_read_enable;
  logic [11:0] core_read_addr;
  logic [31:0] core_read_data;
  logic        oob_error;

  vx_tcu_csr_regs #(.NUM_REGS(8), .ADDR_BITS(12), .BASE_ADDR(12'hCC0)) dut (
    .clk(clk), .reset(reset),
    .tcu_write_enable(tcu_write_enable), .tcu_write_addr(tcu_write_addr),
    .tcu_write_data(tcu_write_data), .tcu_read_enable(tcu_read_enable),
    .tcu_read_addr(tcu_read_addr), .tcu_read_data_a(tcu_read_data_a),
    .tcu_read_data_b(tcu_read_data_b), .core_write_enable(core_write_enable),
    .core_write_addr(core_write_addr), .core_write_data(core_write_data),
    .core_read_enable(core_read_enable), .core_read_addr(core_read_addr),
    .core_read_data(core_read_data), .oob_error(oob_error)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;
  pair_t       tq[$];
  logic [31:0] cq[$];
  logic [31:0] model [8];
  logic        oob_exp;
  int          tests_run = 0;
  int          tests_failed = 0;

  function automatic bit hit(input logic [11:0] addr);
    logic [11:0] off;
    off = addr - 12'hCC0;
    return (addr >= 12'hCC0) && (off < 12'd8);
  endfunction

  function automatic logic [31:0] rd(input logic [11:0] addr, input bit second);
    int i;
    if (!hit(addr)) return 32'h0;
    i = int'(addr - 12'hCC0);
    if (second) return (i == 7) ? 32'h0 : model[i+1];
    return model[i];
  endfunction

  task automatic idle_inputs();
    tcu_write_enable = 0; tcu_read_enable = 0;
    core_write_enable = 0; core_read_enable = 0;
  endtask

  // One cycle of stimulus; the model applies writes before computing reads (write-first).
  task automatic drive(input logic twe, input logic [11:0] twa, input logic [31:0] twd,
                       input logic tre, input logic [11:0] tra,
                       input logic cwe, input logic [11:0] cwa, input logic [31:0] cwd,
                       input logic cre, input logic [11:0] cra);
    pair_t p;
    tcu_write_enable = twe;  tcu_write_addr = twa;  tcu_write_data = twd;
    tcu_read_enable = tre;   tcu_read_addr = tra;
    core_write_enable = cwe; core_write_addr = cwa; core_write_data = cwd;
    core_read_enable = cre;  core_read_addr = cra;
    if (cwe && hit(cwa)) model[int'(cwa - 12'hCC0)] = cwd;
    if (twe && hit(twa)) model[int'(twa - 12'hCC0)] = twd;
    if ((twe && !hit(twa)) || (tre && !hit(tra))) oob_exp = 1'b1;
    if (tre) begin p.a = rd(tra, 0); p.b = rd(tra, 1); tq.push_back(p); end
    if (cre) cq.push_back(rd(cra, 0));
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic tcu_rd(input logic [11:0] a);
    drive(0, 12'h0, 32'h0, 1, a, 0, 12'h0, 32'h0, 0, 12'h0);
  endtask
  task automatic core_wr(input logic [11:0] a, input logic [31:0] d);
    drive(0, 12'h0, 32'h0, 0, 12'h0, 1, a, d, 0, 12'h0);
  endtask
  task automatic core_rd(input logic [11:0] a);
    drive(0, 12'h0, 32'h0, 0, 12'h0, 0, 12'h0, 32'h0, 1, a);
  endtask

  task automatic apply_reset(input logic with_read);
    reset = 1'b1;
    tcu_read_enable = with_read; tcu_read_addr = 12'hCC7;
    core_read_enable = with_read; core_read_addr = 12'hCC7;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    oob_exp = 1'b0;
    tq.delete(); cq.delete();
  endtask

  task automatic test_reset();
    pair_t p;
    apply_reset(1'b0);
    tests_run++; if (tcu_read_data_a !== 32'h0) begin tests_failed++; $display("FAIL reset_data_a: got %h want 0", tcu_read_data_a); end
    tests_run++; if (tcu_read_data_b !== 32'h0) begin tests_failed++; $display("FAIL reset_data_b: got %h want 0", tcu_read_data_b); end
    tests_run++; if (core_read_data !== 32'h0) begin tests_failed++; $display("FAIL reset_core: got %h want 0", core_read_data); end
    tests_run++; if (oob_error !== 1'b0) begin tests_failed++; $display("FAIL reset_oob: got %b want 0", oob_error); end
    tcu_rd(12'hCC0);
    p = tq.pop_front();
    tests_run++; if (tcu_read_data_a !== p.a || tcu_read_data_b !== p.b) begin tests_failed++; $display("FAIL rd_after_reset: got %h/%h want %h/%h", tcu_read_data_a, tcu_read_data_b, p.a, p.b); end
    tests_run++; if (oob_error !== 1'b0) begin tests_failed++; $display("FAIL oob_after_rd: got %b want 0", oob_error); end
  endtask

  task automatic test_paired_read_hold();
    pair_t p;
    core_wr(12'hCC2, 32'h1111_0000);
    core_wr(12'hCC3, 32'h2222_0000);
    tcu_rd(12'hCC2);
    p = tq.pop_front();
    tests_run++; if (tcu_read_data_a !== 32'h1111_0000 || tcu_read_data_b !== 32'h2222_0000) begin tests_failed++; $display("FAIL paired_rd: got %h/%h want 11110000/22220000", tcu_read_data_a, tcu_read_data_b); end
    for (int c = 0; c < 3; c++) begin
      tcu_read_addr = 12'hCC0 + 12'(c);
      core_wr(12'hCC2, 32'h0BAD_0000 + 32'(c));
      tests_run++; if (tcu_read_data_a !== p.a || tcu_read_data_b !== p.b) begin tests_failed++; $display("FAIL hold_%0d: got %h/%h want %h/%h", c, tcu_read_data_a, tcu_read_data_b, p.a, p.b); end
    end
  endtask

  task automatic test_collision();
    pair_t p;
    logic [31:0] c;
    drive(1, 12'hCC4, 32'hAAAA_AAAA, 1, 12'hCC3, 1, 12'hCC4, 32'h5555_5555, 0, 12'h0);
    p = tq.pop_front();
    tests_run++; if (tcu_read_data_b !== 32'hAAAA_AAAA || tcu_read_data_a !== p.a) begin tests_failed++; $display("FAIL collide_fwd: got %h/%h want %h/aaaaaaaa", tcu_read_data_a, tcu_read_data_b, p.a); end
    core_rd(12'hCC4);
    c = cq.pop_front();
    tests_run++; if (core_read_data !== 32'hAAAA_AAAA || c !== 32'hAAAA_AAAA) begin tests_failed++; $display("FAIL collide_core_rd: got %h want aaaaaaaa", core_read_data); end
    // Different addresses in one cycle: both commit, core read forwards its own write.
    drive(1, 12'hCC5, 32'h0000_5A5A, 0, 12'h0, 1, 12'hCC6, 32'h0000_6B6B, 1, 12'hCC6);
    c = cq.pop_front();
    tests_run++; if (core_read_data !== c) begin tests_failed++; $display("FAIL core_fwd: got %h want %h", core_read_data, c); end
    tcu_rd(12'hCC5);
    p = tq.pop_front();
    tests_run++; if (tcu_read_data_a !== p.a || tcu_read_data_b !== p.b) begin tests_failed++; $display("FAIL both_commit: got %h/%h want %h/%h", tcu_read_data_a, tcu_read_data_b, p.a, p.b); end
  endtask

  task automatic test_upper_boundary();
    pair_t p;
    core_wr(12'hCC7, 32'hDEAD_BEEF);
    tcu_rd(12'hCC7);
    p = tq.pop_front();
    tests_run++; if (tcu_read_data_a !== 32'hDEAD_BEEF || tcu_read_data_b !== 32'h0 || p.b !== 32'h0) begin tests_failed++; $display("FAIL upper_wrap: got %h/%h want deadbeef/0", tcu_read_data_a, tcu_read_data_b); end
    tests_run++; if (oob_error !== 1'b0) begin tests_failed++; $display("FAIL upper_oob: got %b want 0", oob_error); end
  endtask

  task automatic test_oob();
    pair_t p;
    logic [31:0] c;
    drive(1, 12'hCC8, 32'h1, 0, 12'h0, 0, 12'h0, 32'h0, 0, 12'h0);
    tests_run++; if (oob_error !== 1'b1) begin tests_failed++; $display("FAIL oob_set: got %b want 1", oob_error); end
    for (int i = 0; i < 8; i++) begin
      core_rd(12'hCC0 + 12'(i));
      c = cq.pop_front();
      tests_run++; if (core_read_data !== c) begin tests_failed++; $display("FAIL oob_regs_%0d: got %h want %h", i, core_read_data, c); end
    end
    tests_run++; if (oob_error !== 1'b1) begin tests_failed++; $display("FAIL oob_sticky: got %b want 1", oob_error); end
    tcu_rd(12'hCBF);
    p = tq.pop_front();
    tests_run++; if (tcu_read_data_a !== p.a || tcu_read_data_b !== p.b || p.a !== 32'h0) begin tests_failed++; $display("FAIL oob_tcu_rd: got %h/%h want 0/0", tcu_read_data_a, tcu_read_data_b); end
    core_rd(12'hCC8);
    c = cq.pop_front();
    tests_run++; if (core_read_data !== c) begin tests_failed++; $display("FAIL oob_core_rd: got %h want %h", core_read_data, c); end
    apply_reset(1'b1);
    tests_run++; if (oob_error !== 1'b0 || tcu_read_data_a !== 32'h0 || core_read_data !== 32'h0) begin tests_failed++; $display("FAIL reset_clear: oob %b a %h core %h want 0", oob_error, tcu_read_data_a, core_read_data); end
    for (int i = 0; i < 8; i++) begin
      core_rd(12'hCC0 + 12'(i));
      c = cq.pop_front();
      tests_run++; if (core_read_data !== 32'h0) begin tests_failed++; $display("FAIL reset_regs_%0d: got %h want 0", i, core_read_data); end
    end
  endtask

  task automatic test_back_to_back();
    pair_t p;
    for (int i = 0; i < 4; i++) core_wr(12'hCC0 + 12'(i), 32'(i + 1));
    for (int i = 0; i < 3; i++) begin
      tcu_rd(12'hCC0 + 12'(i));
      p = tq.pop_front();
      tests_run++; if (tcu_read_data_a !== 32'(i + 1) || tcu_read_data_b !== 32'(i + 2)) begin tests_failed++; $display("FAIL b2b_%0d: got %h/%h want %h/%h", i, tcu_read_data_a, tcu_read_data_b, p.a, p.b); end
    end
  endtask

  task automatic test_random();
    pair_t p;
    pair_t last_t;
    logic [31:0] last_c, c;
    last_t.a = tcu_read_data_a; last_t.b = tcu_read_data_b; last_c = core_read_data;
    for (int n = 0; n < 60; n++) begin
      drive(1'($urandom_range(0, 1)), 12'($urandom_range(12'hCBE, 12'hCC9)), $urandom,
            1'($urandom_range(0, 1)), 12'($urandom_range(12'hCBE, 12'hCC9)),
            1'($urandom_range(0, 1)), 12'($urandom_range(12'hCBE, 12'hCC9)), $urandom,
            1'($urandom_range(0, 1)), 12'($urandom_range(12'hCBE, 12'hCC9)));
      if (tq.size() != 0) last_t = tq.pop_front();
      if (cq.size() != 0) last_c = cq.pop_front();
      p = last_t; c = last_c;
      tests_run++; if (tcu_read_data_a !== p.a || tcu_read_data_b !== p.b) begin tests_failed++; $display("FAIL rand_tcu_%0d: got %h/%h want %h/%h", n, tcu_read_data_a, tcu_read_data_b, p.a, p.b); end
      tests_run++; if (core_read_data !== c) begin tests_failed++; $display("FAIL rand_core_%0d: got %h want %h", n, core_read_data, c); end
      tests_run++; if (oob_error !== oob_exp) begin tests_failed++; $display("FAIL rand_oob_%0d: got %b want %b", n, oob_error, oob_exp); end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tcu_write_addr = '0; tcu_write_data = '0; tcu_read_addr = '0;
    core_write_addr = '0; core_write_data = '0; core_read_addr = '0;
    oob_exp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_paired_read_hold();
    test_collision();
    test_upper_boundary();
    test_oob();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
